// File: rtl/wbl_load_ctrl.sv
// wbl_load_ctrl: starts wbl_key_gen, then walks NUM_ROWS WBL addresses and writes each row to the array.
// Define WBL_LOAD_TIMEOUT_EN to bound the key-gen wait and report a sticky ERR on expiry.
module wbl_load_ctrl #(
  parameter int NUM_ROWS   = 64,
  parameter int SETTLE_CYC = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         ABORT,
  input  logic [127:0] KEY_IN,
  output logic         KG_START,
  output logic [127:0] KG_KIN,
  input  logic         KG_DONE,
  output logic [5:0]   KG_ADDR,
  output logic         WR_REQ,
  output logic [5:0]   WR_ADDR,
  input  logic         WR_ACK,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] KSTART = 3'd1;
  localparam logic [2:0] KWAIT  = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  localparam logic [5:0] LAST_IDX  = 6'(NUM_ROWS - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  logic [2:0]   state_r, state_s;
  logic [5:0]   idx_r, idx_s;
  logic [5:0]   addr_r, addr_s;
  logic [3:0]   settle_r, settle_s;
  logic [127:0] key_r, key_s;
  logic         err_r, err_s;
  logic         kg_start_r, wr_req_r, busy_r, done_r;
`ifdef WBL_LOAD_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]   tmo_r, tmo_s;
`endif

  // Next-state and datapath update; ABORT outranks everything outside IDLE, including WR_ACK
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    addr_s   = addr_r;
    settle_s = settle_r;
    key_s    = key_r;
    err_s    = err_r;
`ifdef WBL_LOAD_TIMEOUT_EN
    tmo_s    = tmo_r;
`endif
    if (ABORT && (state_r != IDLE)) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (START) begin
            state_s = KSTART;
            key_s   = KEY_IN;
            idx_s   = 6'd0;
            err_s   = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        KSTART: begin
          state_s = KWAIT;
`ifdef WBL_LOAD_TIMEOUT_EN
          tmo_s   = 8'd0;
`endif
        end
        KWAIT: begin
          if (KG_DONE) begin
            state_s  = SETTLE;
            settle_s = SETTLE_LD;
            addr_s   = idx_r;
          end
`ifdef WBL_LOAD_TIMEOUT_EN
          else if (tmo_r == TMO_LAST) begin
            state_s = IDLE;
            err_s   = 1'b1;
          end else begin
            tmo_s = tmo_r + 8'd1;
          end
`else
          else begin
            state_s = KWAIT;
          end
`endif
        end
        SETTLE: begin
          if (settle_r <= 4'd1) begin
            state_s  = WRITE;
            settle_s = 4'd0;
          end else begin
            settle_s = settle_r - 4'd1;
          end
        end
        WRITE: begin
          // WR_ACK only matters here, which is exactly when WR_REQ is high
          if (WR_ACK) begin
            if (idx_r == LAST_IDX) begin
              state_s = FINISH;
            end else begin
              state_s  = SETTLE;
              idx_s    = idx_r + 6'd1;
              addr_s   = idx_r + 6'd1;
              settle_s = SETTLE_LD;
            end
          end else begin
            state_s = WRITE;
          end
        end
        FINISH: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State registers; outputs are decoded from the next state so they line up with the state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      idx_r      <= 6'd0;
      addr_r     <= 6'd0;
      settle_r   <= 4'd0;
      key_r      <= 128'd0;
      err_r      <= 1'b0;
      kg_start_r <= 1'b0;
      wr_req_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef WBL_LOAD_TIMEOUT_EN
      tmo_r      <= 8'd0;
`endif
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      addr_r     <= addr_s;
      settle_r   <= settle_s;
      key_r      <= key_s;
      err_r      <= err_s;
      kg_start_r <= (state_s == KSTART);
      wr_req_r   <= (state_s == WRITE);
      busy_r     <= (state_s != IDLE);
      done_r     <= (state_s == FINISH);
`ifdef WBL_LOAD_TIMEOUT_EN
      tmo_r      <= tmo_s;
`endif
    end
  end

  assign KG_START = kg_start_r;
  assign KG_KIN   = key_r;
  assign KG_ADDR  = addr_r;
  assign WR_ADDR  = addr_r;
  assign WR_REQ   = wr_req_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign ERR      = err_r;

endmodule
